score_bcd_sequencer: RTL

- Multi-cycle controller that converts the binary game score into five BCD digits for the per-digit VGA glyph generators.
- Holds each converted result until the next frame boundary so the digits never change mid-frame (no tearing).
- Sits between the game-logic score register and the digit renderers; owns the single shared shift-add-3 (double-dabble) datapath.
- Serialises score updates: one conversion at a time, with a one-deep newest-wins pending slot.

---
 rtl/score_pkg.sv | 18 +
 rtl/bcd_add3_stage.sv | 18 +
 rtl/score_bcd_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score-to-BCD sequencer.
package score_pkg;

  localparam int unsigned SCORE_W    = 17;
  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
  localparam int unsigned MAX_SCORE  = 99999;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {IDLE, CONV, HOLD} seq_state_t;

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_digits_t;

  function automatic logic [SCORE_W-1:0] clamp_score(input logic [SCORE_W-1:0] s);
    clamp_score = (s > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : s;
  endfunction

endpackage

// File: rtl/bcd_add3_stage.sv
// Combinational double-dabble correction: every BCD nibble >= 5 gets +3.
module bcd_add3_stage
  import score_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [BCD_W-1:0] bcd_o
);

  always_comb begin
    bcd_o = bcd_i;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_i[4*k +: 4] >= 4'd5) begin
        bcd_o[4*k +: 4] = bcd_i[4*k +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/score_bcd_sequencer.sv
// Frame-synchronised binary-to-BCD score converter with a newest-wins pending slot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module score_bcd_sequencer
  import score_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SCORE_W-1:0]      score_in,
  input  logic                    score_valid,
  input  logic                    frame_start,
  output logic                    ready,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic                    digits_valid,
  output logic                    saturated,
  output logic [NUM_DIGITS-1:0]   digit_blank
);

  seq_state_t              state_q, state_d;
  logic [SCORE_W-1:0]      shift_q, shift_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_corr;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    clamp_q, clamp_d;
  logic [SCORE_W-1:0]      pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
  logic                    pend_clamp_q, pend_clamp_d;
  logic [BCD_W-1:0]        digits_q, digits_d;
  logic                    valid_q, valid_d;
  logic                    sat_q, sat_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d, blank_next;
  logic [SCORE_W-1:0]      in_clamped;
  logic                    in_over;

  assign in_clamped = clamp_score(score_in);
  assign in_over    = score_in > SCORE_W'(MAX_SCORE);

  bcd_add3_stage u_add3 (
    .bcd_i (bcd_q),
    .bcd_o (bcd_corr)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    logic zero_above;
    blank_next = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (bcd_q[4*k +: 4] == 4'd0);
      blank_next[k] = zero_above;
    end
  end
`else
  assign blank_next = '0;
`endif

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    clamp_d      = clamp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    pend_clamp_d = pend_clamp_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    sat_d        = sat_q;
    blank_d      = blank_q;

    unique case (state_q)
      IDLE: begin
        if (score_valid) begin
          shift_d = in_clamped;
          clamp_d = in_over;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {bcd_corr, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          state_d = HOLD;
        end
        if (score_valid) begin
          pend_d       = in_clamped;
          pend_clamp_d = in_over;
          pend_valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (frame_start) begin
          digits_d = bcd_q;
          sat_d    = clamp_q;
          blank_d  = blank_next;
          valid_d  = 1'b1;
          bcd_d    = '0;
          cnt_d    = '0;
          // A live request is newer than anything pending, so it supersedes the slot.
          if (score_valid) begin
            shift_d      = in_clamped;
            clamp_d      = in_over;
            pend_valid_d = 1'b0;
            state_d      = CONV;
          end else if (pend_valid_q) begin
            shift_d      = pend_q;
            clamp_d      = pend_clamp_q;
            pend_valid_d = 1'b0;
            state_d      = CONV;
          end else begin
            state_d = IDLE;
          end
        end else if (score_valid) begin
          pend_d       = in_clamped;
          pend_clamp_d = in_over;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      clamp_q      <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_clamp_q <= 1'b0;
      digits_q     <= '0;
      valid_q      <= 1'b0;
      sat_q        <= 1'b0;
      blank_q      <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      clamp_q      <= clamp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      pend_clamp_q <= pend_clamp_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      sat_q        <= sat_d;
      blank_q      <= blank_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign digits_out   = digits_q;
  assign digits_valid = valid_q;
  assign saturated    = sat_q;
  assign digit_blank  = blank_q;

endmodule
